// File: rtl/mul_job_sequencer.sv
// Wrapper stage around the 4x4 repeated-addition multiplier: buffers operand pairs,
// issues one job at a time with a single-cycle start, and returns products in order.
//
// state    | meaning
// DRAIN    | post-reset wait for a possibly running multiplier job to finish
// IDLE     | ready to issue the FIFO head once the result slot is free
// ISSUE    | mul_start high for this single cycle
// WAIT_ACK | waiting for the multiplier done flag
// WAIT_LOW | waiting for the done flag to drop so it is not taken twice
module mul_job_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int RESET_DRAIN = 20
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_a,
  output logic [3:0] out_b,
  output logic [7:0] out_p,
  output logic       mul_start,
  output logic [3:0] mul_a,
  output logic [3:0] mul_b,
  input  logic [7:0] mul_result,
  input  logic       mul_ack,
  output logic       busy,
  output logic [7:0] jobs_done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(RESET_DRAIN + 1);

  localparam logic [2:0] DRAIN    = 3'd0;
  localparam logic [2:0] IDLE     = 3'd1;
  localparam logic [2:0] ISSUE    = 3'd2;
  localparam logic [2:0] WAIT_ACK = 3'd3;
  localparam logic [2:0] WAIT_LOW = 3'd4;

  logic [2:0]    state;
  logic [DW-1:0] drain_cnt;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign in_ready = !full && (state != DRAIN) && Rst_n;
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && !empty && !out_valid;
  assign busy     = (state != IDLE) || !empty;

  always_ff @(posedge Clk) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= {in_a, in_b};
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state     <= DRAIN;
      drain_cnt <= DW'(RESET_DRAIN);
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_a     <= 4'd0;
      out_b     <= 4'd0;
      out_p     <= 8'd0;
      mul_start <= 1'b0;
      mul_a     <= 4'd0;
      mul_b     <= 4'd0;
      jobs_done <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        DRAIN: begin
          if (drain_cnt == '0) state <= IDLE;
          else                 drain_cnt <= drain_cnt - 1'b1;
        end
        IDLE: begin
          if (pop) begin
            {mul_a, mul_b} <= fifo_mem[rd_ptr[PW-1:0]];
            mul_start      <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          mul_start <= 1'b0;
          state     <= WAIT_ACK;
        end
        // The slot is always free here: issue only happens while out_valid is low.
        WAIT_ACK: begin
          if (mul_ack) begin
            out_p     <= mul_result;
            out_a     <= mul_a;
            out_b     <= mul_b;
            out_valid <= 1'b1;
            jobs_done <= jobs_done + 8'd1;
            state     <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!mul_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_job_sequencer.sv
// Randomized scoreboard bench for mul_job_sequencer with a behavioural
// repeated-addition multiplier attached to the mul_* interface.
module tb_mul_job_sequencer;

  localparam int RESET_DRAIN = 20;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = 4'd0;
  logic [3:0] in_b = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_a;
  logic [3:0] out_b;
  logic [7:0] out_p;
  logic       mul_start;
  logic [3:0] mul_a;
  logic [3:0] mul_b;
  logic [7:0] mul_result = 8'd0;
  logic       mul_ack = 1'b0;
  logic       busy;
  logic [7:0] jobs_done;

  mul_job_sequencer #(.FIFO_DEPTH(4), .RESET_DRAIN(RESET_DRAIN)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_p(out_p),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .mul_ack(mul_ack),
    .busy(busy), .jobs_done(jobs_done)
  );

  always #5 Clk = ~Clk;

  // Multiplier model: no reset, samples start, adds a once per b, then a 1-cycle ack.
  logic       m_busy = 1'b0;
  logic [3:0] m_a = 4'd0;
  logic [3:0] m_cnt = 4'd0;
  logic [7:0] m_acc = 8'd0;
  always @(posedge Clk) begin
    if (m_busy) begin
      if (m_cnt != 0) begin
        m_acc <= m_acc + {4'd0, m_a};
        m_cnt <= m_cnt - 4'd1;
      end else begin
        mul_ack    <= 1'b1;
        mul_result <= m_acc;
        m_busy     <= 1'b0;
      end
    end else begin
      mul_ack <= 1'b0;
      if (mul_start) begin
        m_busy <= 1'b1;
        m_a    <= mul_a;
        m_cnt  <= mul_b;
        m_acc  <= 8'd0;
      end
    end
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int consumed = 0;
  int n_starts = 0;
  int start_cyc = 0;
  int start_b = 0;
  int hs_cyc = 0;
  logic prev_start = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  logic [7:0] held_p = 8'd0;
  logic [3:0] held_a = 4'd0;
  logic [3:0] held_b = 4'd0;
  bit rnd_run = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: scoreboard pops, latency, start-pulse shape and slot stability.
  always @(negedge Clk) begin
    if (Rst_n) begin
      if (mul_start) begin
        chk("start_single_cycle", int'(prev_start), 0);
        chk("start_with_slot_full", int'(out_valid), 0);
        if (!prev_start) begin
          n_starts++;
          start_cyc = cyc;
          start_b = int'(mul_b);
        end
      end
      if (out_valid && !prev_valid)
        chk("latency", cyc - start_cyc, start_b + 3);
      if (out_valid && prev_valid && !prev_ready) begin
        chk("hold_p", int'(out_p), int'(held_p));
        chk("hold_a", int'(out_a), int'(held_a));
        chk("hold_b", int'(out_b), int'(held_b));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_p", int'(out_p), int'(e.p));
          chk("out_a", int'(out_a), int'(e.a));
          chk("out_b", int'(out_b), int'(e.b));
        end
        chk("jobs_done", int'(jobs_done), (consumed + 1) % 256);
        consumed++;
        hs_cyc = cyc;
      end
    end
    prev_start = mul_start;
    prev_valid = out_valid;
    prev_ready = out_ready;
    held_p = out_p;
    held_a = out_a;
    held_b = out_b;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the pair has been accepted.
  task automatic push(input logic [3:0] a, input logic [3:0] b);
    bit done;
    exp_t e;
    done = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 400 && !done; i++) begin
      if (in_ready) done = 1'b1;
      @(posedge Clk);
      if (done) begin
        e.a = a;
        e.b = b;
        e.p = 8'(int'(a) * int'(b));
        exp_q.push_back(e);
      end
      #1;
    end
    in_valid = 1'b0;
    if (!done) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      if (exp_q.size() == 0 && !busy && !out_valid) ok = 1'b1;
      else tick(1);
    end
    chk("idle_reached", int'(ok), 1);
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    exp_q.delete();
    consumed = 0;
    tick(1);
    Rst_n = 1'b1;
  endtask

  initial begin
    int s0;
    bit stalled;
    bit seen;

    // Reset state
    tick(2);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_mul_start", int'(mul_start), 0);
    chk("rst_jobs_done", int'(jobs_done), 0);
    chk("rst_out_p", int'(out_p), 0);
    chk("rst_busy", int'(busy), 1);
    Rst_n = 1'b1;
    for (int i = 0; i < RESET_DRAIN; i++) begin
      chk("drain_in_ready", int'(in_ready), 0);
      tick(1);
    end
    wait_idle(50);

    // Single job
    s0 = n_starts;
    push(4'd12, 4'd6);
    wait_idle(100);
    chk("single_starts", n_starts - s0, 1);
    chk("single_jobs_done", int'(jobs_done), 1);

    // Edge operands
    push(4'd7, 4'd0);
    push(4'd0, 4'd9);
    push(4'd15, 4'd15);
    wait_idle(200);

    // FIFO full: long first job keeps the FIFO from draining
    push(4'd1, 4'd15);
    push(4'd2, 4'd3);
    push(4'd3, 4'd4);
    push(4'd4, 4'd5);
    push(4'd5, 4'd6);
    chk("full_in_ready", int'(in_ready), 0);
    chk("full_busy", int'(busy), 1);
    wait_idle(400);

    // Backpressure
    out_ready = 1'b0;
    s0 = n_starts;
    push(4'd5, 4'd3);
    push(4'd6, 4'd2);
    tick(30);
    chk("bp_starts", n_starts - s0, 1);
    chk("bp_out_valid", int'(out_valid), 1);
    chk("bp_out_p", int'(out_p), 15);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      if (n_starts - s0 == 2) seen = 1'b1;
    end
    chk("bp_second_issue_seen", int'(seen), 1);
    chk("bp_issue_gap", start_cyc - hs_cyc, 2);
    wait_idle(100);

    // Reset mid-job
    s0 = n_starts;
    push(4'd9, 4'd15);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      if (n_starts != s0) seen = 1'b1;
    end
    chk("midrst_started", int'(seen), 1);
    tick(5);
    do_reset();
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_p", int'(out_p), 0);
    chk("midrst_mul_start", int'(mul_start), 0);
    chk("midrst_mul_a", int'(mul_a), 0);
    chk("midrst_jobs_done", int'(jobs_done), 0);
    for (int i = 0; i < RESET_DRAIN; i++) begin
      chk("midrst_in_ready", int'(in_ready), 0);
      chk("midrst_ack_ignored", int'(out_valid), 0);
      tick(1);
    end
    push(4'd3, 4'd4);
    wait_idle(100);
    chk("midrst_jobs_after", int'(jobs_done), 1);

    // Randomized traffic with random backpressure
    rnd_run = 1'b1;
    fork
      begin
        while (rnd_run) begin
          @(posedge Clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 40; i++) begin
      push(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 10));
    end
    rnd_run = 1'b0;
    tick(2);
    out_ready = 1'b1;
    wait_idle(2000);

    // Counter wrap
    do_reset();
    wait_idle(50);
    stalled = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (!in_ready) stalled = 1'b1;
      push(4'd2, 4'd1);
    end
    wait_idle(5000);
    chk("wrap_jobs_done", int'(jobs_done), 0);
    chk("wrap_consumed", consumed, 256);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_job_sequencer.md
Name: mul_job_sequencer

Overview:
- Upstream/downstream wrapper stage for the 4x4 repeated-addition multiplier (start/ack handshake, 8-bit product).
- Accepts operand pairs on a valid/ready stream and buffers them in a 4-entry FIFO.
- Issues one job at a time to the multiplier, with a clean start pulse and stale-ack protection.
- Returns each product with its operands on a valid/ready output stream.

Parameters:
- FIFO_DEPTH, 4: operand FIFO entries (power of two).
- RESET_DRAIN, 20: cycles after reset during which no job is issued. Must be at least 18, the worst-case multiplier job length.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  sequencer accepts the pair this cycle.
- in_a  in  4  multiplicand.
- in_b  in  4  multiplier (sets job length).
- out_valid  out  1  result slot holds a product.
- out_ready  in  1  consumer takes the result this cycle.
- out_a  out  4  operand a of the returned job.
- out_b  out  4  operand b of the returned job.
- out_p  out  8  product.
- mul_start  out  1  start to the multiplier; registered.
- mul_a  out  4  operand a to the multiplier; registered.
- mul_b  out  4  operand b to the multiplier; registered.
- mul_result  in  8  multiplier result.
- mul_ack  in  1  multiplier done flag.
- busy  out  1  high in any state except IDLE, or while the FIFO is non-empty.
- jobs_done  out  8  count of completed jobs; wraps 255 -> 0.

Behaviour:
- Reset (sampled Rst_n=0), all registered:
  - in_ready=0, out_valid=0, out_a/out_b/out_p=0, mul_start=0, mul_a/mul_b=0, jobs_done=0.
  - FIFO emptied; state=DRAIN with drain counter loaded to RESET_DRAIN.
  - Reset mid-job is legal. The multiplier has no reset, so DRAIN waits it out; mul_ack is ignored in DRAIN.
- in_ready = !full && state!=DRAIN && Rst_n.
- Push on in_valid&&in_ready. Simultaneous push and pop is allowed. No push when full, even if a pop occurs in the same cycle.
- States:
  - DRAIN: counter decrements each cycle; at 0 go to IDLE.
  - IDLE: if FIFO non-empty and out_valid=0, pop the head into mul_a/mul_b, set mul_start=1, go to ISSUE.
  - ISSUE: exactly one cycle. mul_start<=0; go to WAIT_ACK.
  - WAIT_ACK: on mul_ack=1, capture out_p<=mul_result and out_a/out_b<=mul_a/mul_b, set out_valid<=1, increment jobs_done, go to WAIT_LOW.
  - WAIT_LOW: stay until mul_ack=0, then go to IDLE. This guarantees no stale ack is taken as the next completion.
- mul_start is high for exactly one cycle per job. mul_a/mul_b are held stable from issue until the next issue.
- Latency:
  - mul_start rises after edge t.
  - The multiplier samples it at edge t+1.
  - ack rises at edge t+2+b.
  - out_valid rises after edge t+3+b, i.e. b+3 cycles after mul_start rises.
  - b=0 gives 3 cycles.
- Output slot:
  - out_valid and its data are held stable until out_valid&&out_ready; cleared on that edge.
  - The next job may issue from IDLE the cycle after the slot empties.
  - No issue while out_valid=1 (the 1-cycle ack must always find the slot free).
- Arithmetic: the product is taken from the multiplier unmodified; 15*15=225 fits 8 bits. jobs_done wraps modulo 256.
- Job order: FIFO order is preserved; products return in push order.

Test Plan:
- Single job: after drain, push a=12, b=6 -> exactly one mul_start pulse. Then out_valid, out_p=72, out_a=12, out_b=6 appears 9 cycles after mul_start; jobs_done=1.
- Edge operands: push (7,0), (0,9), (15,15) with out_ready=1 -> out_p = 0, 0, 225 in order. out_valid rises 3, 12 and 18 cycles after the respective mul_start.
- FIFO full: push 5 pairs back-to-back while the first job runs -> in_ready drops after 4 are buffered (the first popped frees one slot). All 5 products are returned in order, none lost or duplicated.
- Backpressure: out_ready=0 for 30 cycles with 2 jobs queued -> out_p holds the first product, no mul_start while out_valid=1. On out_ready=1 the second job issues the next IDLE cycle.
- Reset mid-job: Rst_n=0 for 1 cycle during a 15-cycle multiply -> outputs zeroed, in_ready=0 for RESET_DRAIN cycles, the late mul_ack is ignored. A new push (3,4) then returns 12.
- Counter wrap: 256 jobs (2,1) -> jobs_done reaches 255 then reads 0; every out_p=2.
